pipe_scheduler: RTL and testbench

- Sequences the two scrolling pipe slots of the Flappy Bird playfield.
- Steps each pipe's X position on a movement tick and respawns a pipe at the right edge when it leaves the screen.
- On each respawn, fetches that pipe's gap height from the pattern source over a req/ack handshake; also keeps the score.
- Sits between the game-control logic (Start/Crash) and the pattern generator; its X/gap outputs feed the renderer and collision logic.

---
 rtl/pipe_pkg.sv | 36 +++
 rtl/gap_fetch.sv | 45 ++++
 rtl/pipe_scheduler.sv | 110 +++++++++++
 tb/tb_pipe_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - playfield geometry, gap bounds and scheduler state shared with renderer and pattern source
package pipe_pkg;

  localparam int COORD_W = 16;

  typedef enum logic [1:0] {IDLE, FILL, RUN, HALT} state_t;

  localparam logic [COORD_W-1:0] SCREEN_W     = 16'd640;
  localparam logic [COORD_W-1:0] PIPE_SPACING = 16'd320;
  localparam logic [COORD_W-1:0] PIPE2_START  = SCREEN_W + PIPE_SPACING;
  localparam logic [COORD_W-1:0] BIRD_X       = 16'd160;
  localparam logic [COORD_W-1:0] STEP         = 16'd1;
  localparam logic [COORD_W-1:0] GAP_DEFAULT  = 16'd100;
  localparam logic [COORD_W-1:0] GAP_MIN      = 16'd40;
  localparam logic [COORD_W-1:0] GAP_MAX      = 16'd160;

  function automatic logic [COORD_W-1:0] clamp_gap(input logic [COORD_W-1:0] v);
    if (v < GAP_MIN)
      return GAP_MIN;
    else if (v > GAP_MAX)
      return GAP_MAX;
    else
      return v;
  endfunction

  // A pipe sitting at X=0 wraps to the right edge; otherwise it moves left, never below 0.
  function automatic logic [COORD_W-1:0] next_x(input logic [COORD_W-1:0] x);
    if (x == '0)
      return SCREEN_W;
    else if (x < STEP)
      return '0;
    else
      return x - STEP;
  endfunction

endpackage

// File: rtl/gap_fetch.sv
// rtl/gap_fetch.sv - per-slot refill requests to the pattern source with slot priority and gap clamping
module gap_fetch
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  set_pend,
  input  logic        ack,
  input  logic [15:0] value,
  output logic        req,
  output logic        slot,
  output logic        busy,
  output logic        wr_en,
  output logic        wr_slot,
  output logic [15:0] wr_value
);

  logic [1:0] pending;
  logic [1:0] clr;

  assign wr_en    = req & ack;
  assign wr_slot  = slot;
  assign wr_value = clamp_gap(value);
  assign clr      = wr_en ? (slot ? 2'b10 : 2'b01) : 2'b00;
  assign busy     = |pending;

  // A new set wins over a same-cycle completion so a restart always refetches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 2'b00;
      req     <= 1'b0;
      slot    <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | set_pend;
      if (req) begin
        if (ack)
          req <= 1'b0;
      end else if (|pending) begin
        req  <= 1'b1;
        slot <= ~pending[0];
      end
    end
  end

endmodule

// File: rtl/pipe_scheduler.sv
// rtl/pipe_scheduler.sv - game-state FSM, pipe X counters and score for the two scrolling pipe slots
module pipe_scheduler
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start,
  input  logic        crash,
  input  logic        gap_ack,
  input  logic [15:0] gap_value,
  output logic        gap_req,
  output logic        gap_slot,
  output logic [15:0] pipe1_x,
  output logic [15:0] pipe2_x,
  output logic [15:0] gap1,
  output logic [15:0] gap2,
  output logic [15:0] score,
  output logic        running,
  output logic        halted
);

  state_t      state;
  logic [1:0]  set_pend;
  logic        busy;
  logic        wr_en;
  logic        wr_slot;
  logic [15:0] wr_value;
  logic [1:0]  score_inc;
  logic [16:0] score_sum;
  logic [15:0] score_next;

  gap_fetch u_gap_fetch (
    .clk      (clk),
    .rst      (rst),
    .set_pend (set_pend),
    .ack      (gap_ack),
    .value    (gap_value),
    .req      (gap_req),
    .slot     (gap_slot),
    .busy     (busy),
    .wr_en    (wr_en),
    .wr_slot  (wr_slot),
    .wr_value (wr_value)
  );

  always_comb begin
    set_pend = 2'b00;
    case (state)
      IDLE:    if (start) set_pend = 2'b11;
      HALT:    if (start) set_pend = 2'b11;
      RUN:     if (tick && !crash) set_pend = {pipe2_x == '0, pipe1_x == '0};
      default: set_pend = 2'b00;
    endcase
  end

  always_comb begin
    score_inc  = {1'b0, pipe1_x == BIRD_X} + {1'b0, pipe2_x == BIRD_X};
    score_sum  = {1'b0, score} + {15'b0, score_inc};
    score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pipe1_x <= SCREEN_W;
      pipe2_x <= PIPE2_START;
      gap1    <= GAP_DEFAULT;
      gap2    <= GAP_DEFAULT;
      score   <= '0;
      running <= 1'b0;
      halted  <= 1'b0;
    end else begin
      if (wr_en) begin
        if (wr_slot)
          gap2 <= wr_value;
        else
          gap1 <= wr_value;
      end
      case (state)
        IDLE: if (start) state <= FILL;
        FILL: if (!busy) begin
          state   <= RUN;
          running <= 1'b1;
        end
        RUN: if (crash) begin
          state   <= HALT;
          running <= 1'b0;
          halted  <= 1'b1;
        end else if (tick) begin
          pipe1_x <= next_x(pipe1_x);
          pipe2_x <= next_x(pipe2_x);
          score   <= score_next;
        end
        // The restart reload takes precedence over a gap landing in the same cycle.
        HALT: if (start) begin
          state   <= FILL;
          halted  <= 1'b0;
          pipe1_x <= SCREEN_W;
          pipe2_x <= PIPE2_START;
          gap1    <= GAP_DEFAULT;
          gap2    <= GAP_DEFAULT;
          score   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_scheduler.sv
// tb/tb_pipe_scheduler.sv - scoreboard bench for pipe_scheduler with directed stimulus
module tb_pipe_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        crash = 1'b0;
  logic        gap_ack = 1'b0;
  logic [15:0] gap_value = 16'd0;
  logic        gap_req;
  logic        gap_slot;
  logic [15:0] pipe1_x;
  logic [15:0] pipe2_x;
  logic [15:0] gap1;
  logic [15:0] gap2;
  logic [15:0] score;
  logic        running;
  logic        halted;

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];
  logic mon_prev = 1'b0;
  logic mon_held = 1'b0;
  logic mon_exp;

  pipe_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .start     (start),
    .crash     (crash),
    .gap_ack   (gap_ack),
    .gap_value (gap_value),
    .gap_req   (gap_req),
    .gap_slot  (gap_slot),
    .pipe1_x   (pipe1_x),
    .pipe2_x   (pipe2_x),
    .gap1      (gap1),
    .gap2      (gap2),
    .score     (score),
    .running   (running),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && !gap_req; i++) step();
    chk("req_seen", gap_req, 1);
  endtask

  task automatic answer(input logic [15:0] v, input int delay);
    wait_req();
    repeat (delay) step();
    gap_ack   = 1'b1;
    gap_value = v;
    step();
    gap_ack   = 1'b0;
    chk("req_drop", gap_req, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pipe1"}, pipe1_x, 640);
    chk({tag, "_pipe2"}, pipe2_x, 960);
    chk({tag, "_gap1"}, gap1, 100);
    chk({tag, "_gap2"}, gap2, 100);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_req"}, gap_req, 0);
    chk({tag, "_slot"}, gap_slot, 0);
    chk({tag, "_running"}, running, 0);
    chk({tag, "_halted"}, halted, 0);
  endtask

  // Monitor: every new request is matched against the slot the stimulus predicted.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_prev = 1'b0;
      end else begin
        if (gap_req && !mon_prev) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL req_unexpected: got slot %0d expected no request", gap_slot);
          end else begin
            mon_exp = exp_q.pop_front();
            chk("req_slot", gap_slot, mon_exp);
          end
          mon_held = gap_slot;
        end else if (gap_req) begin
          chk("slot_stable", gap_slot, mon_held);
        end
        mon_prev = gap_req;
      end
    end
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    step();
    check_reset_outputs("idle");

    // Initial fill: slot 0 then slot 1
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("fill_running", running, 0);
    answer(16'd80, 0);
    chk("fill_gap1", gap1, 80);
    chk("fill_gap2_old", gap2, 100);
    answer(16'd140, 0);
    chk("fill_gap2", gap2, 140);
    step();
    chk("fill_to_run", running, 1);
    chk("fill_pipe1_frozen", pipe1_x, 640);
    chk("fill_pipe2_frozen", pipe2_x, 960);
    chk("fill_req_count", exp_q.size(), 0);

    // Scrolling and scoring
    ticks(479);
    chk("run_pipe1_161", pipe1_x, 161);
    chk("run_pipe2_481", pipe2_x, 481);
    chk("run_score0", score, 0);
    ticks(2);
    chk("run_pipe1_159", pipe1_x, 159);
    chk("run_score1", score, 1);
    ticks(159);
    chk("run_pipe1_0", pipe1_x, 0);
    chk("run_pipe2_320", pipe2_x, 320);
    exp_q.push_back(1'b0);
    ticks(1);
    chk("wrap_pipe1", pipe1_x, 640);
    chk("wrap_pipe2", pipe2_x, 319);
    chk("wrap_req_latency", gap_req, 0);
    step();
    chk("wrap_req", gap_req, 1);
    chk("wrap_slot", gap_slot, 0);
    answer(16'd395, 0);
    chk("clamp_high", gap1, 160);
    ticks(160);
    chk("score2", score, 2);
    chk("run_pipe2_159", pipe2_x, 159);
    chk("run_pipe1_480", pipe1_x, 480);
    ticks(159);
    chk("run_pipe2_0", pipe2_x, 0);
    exp_q.push_back(1'b1);
    ticks(1);
    chk("wrap2_pipe2", pipe2_x, 640);
    chk("wrap2_pipe1", pipe1_x, 320);
    answer(16'd10, 0);
    chk("clamp_low", gap2, 40);
    chk("clamp_gap1_kept", gap1, 160);

    // Crash with tick in the same cycle
    ticks(120);
    chk("pre_crash_pipe1", pipe1_x, 200);
    crash = 1'b1;
    tick  = 1'b1;
    step();
    crash = 1'b0;
    tick  = 1'b0;
    chk("crash_pipe1", pipe1_x, 200);
    chk("crash_pipe2", pipe2_x, 520);
    chk("crash_halted", halted, 1);
    chk("crash_running", running, 0);
    chk("crash_score", score, 2);
    ticks(3);
    chk("halt_frozen", pipe1_x, 200);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_score", score, 0);
    chk("restart_pipe1", pipe1_x, 640);
    chk("restart_pipe2", pipe2_x, 960);
    chk("restart_gap1", gap1, 100);
    chk("restart_halted", halted, 0);
    chk("restart_fill", running, 0);
    answer(16'd90, 0);
    answer(16'd120, 0);
    step();
    chk("restart_run", running, 1);
    chk("restart_gap1_new", gap1, 90);
    chk("restart_gap2_new", gap2, 120);

    // Crash with a request outstanding, ack arrives late in HALT
    ticks(640);
    chk("late_pipe1_0", pipe1_x, 0);
    chk("late_score", score, 1);
    exp_q.push_back(1'b0);
    ticks(1);
    step();
    chk("late_req", gap_req, 1);
    crash = 1'b1;
    step();
    crash = 1'b0;
    chk("late_halted", halted, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("late_req_held", gap_req, 1);
    end
    gap_ack   = 1'b1;
    gap_value = 16'd150;
    step();
    gap_ack   = 1'b0;
    chk("late_gap1", gap1, 150);
    chk("late_req_drop", gap_req, 0);
    chk("late_still_halted", halted, 1);
    chk("late_score_frozen", score, 1);
    step();
    chk("late_no_rereq", gap_req, 0);

    // Asynchronous reset in the middle of a handshake
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    answer(16'd70, 0);
    chk("mid_gap1", gap1, 70);
    wait_req();
    chk("mid_slot1", gap_slot, 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async");
    exp_q.delete();
    repeat (2) step();
    rst = 1'b0;
    gap_ack   = 1'b1;
    gap_value = 16'd77;
    repeat (3) step();
    gap_ack = 1'b0;
    chk("post_rst_gap1", gap1, 100);
    chk("post_rst_gap2", gap2, 100);
    chk("post_rst_req", gap_req, 0);
    chk("post_rst_running", running, 0);
    step();
    chk("post_rst_idle_req", gap_req, 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
